// File: rtl/cmp_harness_pkg.sv
// cmp_harness_pkg: shared mode and capture-state encodings for the compressor scan harness
package cmp_harness_pkg;
    typedef enum logic [1:0] {HOLD = 2'b00, SHIFT_IN = 2'b01, CAPTURE = 2'b10, SHIFT_OUT = 2'b11} mode_t;
    typedef enum logic [1:0] {IDLE, WAIT, VALID, DRAIN} cap_state_t;
endpackage

// File: rtl/cmp_lane_sreg.sv
// cmp_lane_sreg: WIDTH-bit serial-in shift register, LSB entry, shifts when en is high
module cmp_lane_sreg #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;
    // next value: shift din in at the LSB when enabled
    always_comb q_d = en ? {q_q[WIDTH-2:0], din} : q_q;
    // lane register
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/cmp_scan_harness.sv
// cmp_scan_harness: serial operand load, latency-aware result capture and serial readout
module cmp_scan_harness
    import cmp_harness_pkg::*;
#(
    parameter int NCH   = 14,
    parameter int WIDTH = 14,
    parameter int DW    = 18,
    parameter int LAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [NCH-1:0]       din,
    output logic [NCH*WIDTH-1:0] src,
    input  logic [DW-1:0]        dst,
    output logic                 dout,
    output logic                 loaded,
    output logic                 res_valid,
    output logic                 drained
);
    localparam int IW = $clog2(WIDTH + 1);
    localparam int OW = $clog2(DW + 1);
    localparam int LW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    mode_t      m;
    cap_state_t state_q, state_d;
    logic [DW-1:0] res_q, res_d;
    logic [IW-1:0] in_cnt_q, in_cnt_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic          drained_q, drained_d;

    assign m = mode_t'(mode);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        cmp_lane_sreg #(.WIDTH(WIDTH)) u_lane (
            .clk(clk),
            .rst(rst),
            .en (m == SHIFT_IN),
            .din(din[i]),
            .q  (src[i*WIDTH +: WIDTH])
        );
    end

    // load counter: saturates at WIDTH, cleared by any capture request
    always_comb begin
        in_cnt_d = in_cnt_q;
        if (m == SHIFT_IN && in_cnt_q != IW'(WIDTH)) in_cnt_d = in_cnt_q + IW'(1);
        if (m == CAPTURE) in_cnt_d = '0;
    end

    // capture FSM: SHIFT_IN invalidates everything, capture restarts, WAIT counts out the latency
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        lat_cnt_d = lat_cnt_q;
        out_cnt_d = out_cnt_q;
        drained_d = drained_q;
        if (m == SHIFT_IN) begin
            state_d   = IDLE;
            drained_d = 1'b0;
        end else if (m == CAPTURE && state_q != WAIT) begin
            out_cnt_d = '0;
            drained_d = 1'b0;
            lat_cnt_d = '0;
            state_d   = (LAT == 0) ? VALID : WAIT;
            res_d     = (LAT == 0) ? dst : res_q;
        end else if (state_q == WAIT) begin
            lat_cnt_d = lat_cnt_q + LW'(1);
            if (lat_cnt_q == LW'(LAT - 1)) begin
                res_d   = dst;
                state_d = VALID;
            end
        end else if (m == SHIFT_OUT && (state_q == VALID || state_q == DRAIN)) begin
            res_d     = {res_q[DW-2:0], 1'b0};
            out_cnt_d = out_cnt_q + OW'(1);
            drained_d = (out_cnt_d == OW'(DW));
            state_d   = drained_d ? IDLE : DRAIN;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q   <= IDLE;
            res_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            lat_cnt_q <= '0;
            drained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            drained_q <= drained_d;
        end

    assign dout      = res_q[DW-1];
    assign loaded    = (in_cnt_q == IW'(WIDTH));
    assign res_valid = (state_q == VALID || state_q == DRAIN);
    assign drained   = drained_q;
endmodule
